cam_sccb_responder: RTL and testbench

//  SCCB/I2C target (slave) that answers the camera-config master on the SCL/SDA pair.

---
 rtl/cam_sccb_pkg.sv | 22 ++
 rtl/cam_sccb_responder_if.sv | 24 ++
 rtl/cam_sccb_line_sync.sv | 50 +++++
 rtl/cam_sccb_responder.sv | 175 +++++++++++++++++
 tb/tb_cam_sccb_responder.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/cam_sccb_pkg.sv
// Shared types and constants for the SCCB register-bank responder.
package cam_sccb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV,
    ST_DEV_ACK,
    ST_REG,
    ST_REG_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_MACK,
    ST_WAIT_STOP
  } sccb_state_t;

  localparam logic [7:0] SCCB_WR_ADDR = 8'h42;
  localparam logic [7:0] SCCB_RD_ADDR = 8'h43;
  localparam logic       ACK          = 1'b0;
  localparam logic       NACK         = 1'b1;

endpackage

// File: rtl/cam_sccb_responder_if.sv
// SCCB line pair plus host register-bank port of the responder.
interface cam_sccb_responder_if;

  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  logic       reg_wr_en;
  logic       reg_rd_en;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       busy;

  modport slave (
    input  scl_in, sda_in, reg_rdata,
    output sda_oe, reg_wr_en, reg_rd_en, reg_addr, reg_wdata, busy
  );

  modport master (
    output scl_in, sda_in, reg_rdata,
    input  sda_oe, reg_wr_en, reg_rd_en, reg_addr, reg_wdata, busy
  );

endinterface

// File: rtl/cam_sccb_line_sync.sv
// Synchronises SCL/SDA, applies a 2-sample stability filter and flags bus events.
module cam_sccb_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_det_o,
  output logic stop_det_o,
  output logic sda_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic scl_smp_q, sda_smp_q;
  logic scl_flt_q, sda_flt_q;
  logic scl_prv_q, sda_prv_q;

  // Everything resets to the idle-high bus level so release from reset cannot fake an event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_smp_q  <= 1'b1;
      sda_smp_q  <= 1'b1;
      scl_flt_q  <= 1'b1;
      sda_flt_q  <= 1'b1;
      scl_prv_q  <= 1'b1;
      sda_prv_q  <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_smp_q  <= scl_sync_q[SYNC_STAGES-1];
      sda_smp_q  <= sda_sync_q[SYNC_STAGES-1];
      if (scl_sync_q[SYNC_STAGES-1] == scl_smp_q) scl_flt_q <= scl_smp_q;
      if (sda_sync_q[SYNC_STAGES-1] == sda_smp_q) sda_flt_q <= sda_smp_q;
      scl_prv_q  <= scl_flt_q;
      sda_prv_q  <= sda_flt_q;
    end
  end

  assign scl_rise_o  = scl_flt_q & ~scl_prv_q;
  assign scl_fall_o  = ~scl_flt_q & scl_prv_q;
  assign start_det_o = scl_flt_q & scl_prv_q & sda_prv_q & ~sda_flt_q;
  assign stop_det_o  = scl_flt_q & scl_prv_q & ~sda_prv_q & sda_flt_q;
  assign sda_o       = sda_flt_q;

endmodule

// File: rtl/cam_sccb_responder.sv
// SCCB target: decodes device/pointer/data bytes and drives single-cycle register-bank strobes.
module cam_sccb_responder
  import cam_sccb_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = SCCB_WR_ADDR[7:1],
  parameter int         SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  cam_sccb_responder_if.slave  bus
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  cam_sccb_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk         (clk),
    .reset       (reset),
    .scl_i       (bus.scl_in),
    .sda_i       (bus.sda_in),
    .scl_rise_o  (scl_rise),
    .scl_fall_o  (scl_fall),
    .start_det_o (start_det),
    .stop_det_o  (stop_det),
    .sda_o       (sda_s)
  );

  sccb_state_t state_q;
  logic [3:0]  cnt_q;
  logic [6:0]  sh_q;
  logic [7:0]  tx_q;
  logic        ph_q, rw_q, lat_q;
  logic        sda_oe_q, wr_q, rd_q, busy_q;
  logic [7:0]  addr_q, wdata_q;
  logic [7:0]  rx_byte_d;

  assign rx_byte_d = {sh_q, sda_s};

  // ph_q marks the second half of a two-step slot: ACK being driven, or master ACK seen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      sh_q     <= '0;
      tx_q     <= '0;
      ph_q     <= 1'b0;
      rw_q     <= 1'b0;
      lat_q    <= 1'b0;
      sda_oe_q <= 1'b0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      busy_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      lat_q <= rd_q;
      if (lat_q) tx_q <= bus.reg_rdata;
      if (wr_q) addr_q <= addr_q + 8'd1;

      if (stop_det) begin
        state_q  <= ST_IDLE;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
        ph_q     <= 1'b0;
      end else if (start_det) begin
        state_q  <= ST_DEV;
        cnt_q    <= '0;
        sda_oe_q <= 1'b0;
        ph_q     <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE, ST_WAIT_STOP: sda_oe_q <= 1'b0;

          ST_DEV, ST_REG, ST_WDATA: begin
            if (scl_rise) begin
              sh_q <= rx_byte_d[6:0];
              if (cnt_q == 4'd7) begin
                cnt_q <= '0;
                ph_q  <= 1'b0;
                if (state_q == ST_DEV) begin
                  if (rx_byte_d[7:1] == DEV_ADDR) begin
                    state_q <= ST_DEV_ACK;
                    busy_q  <= 1'b1;
                    rw_q    <= rx_byte_d[0];
                  end else begin
                    state_q <= ST_WAIT_STOP;
                    busy_q  <= 1'b0;
                  end
                end else if (state_q == ST_REG) begin
                  addr_q  <= rx_byte_d;
                  state_q <= ST_REG_ACK;
                end else begin
                  wr_q    <= 1'b1;
                  wdata_q <= rx_byte_d;
                  state_q <= ST_WDATA_ACK;
                end
              end else begin
                cnt_q <= cnt_q + 4'd1;
              end
            end
          end

          ST_DEV_ACK, ST_REG_ACK, ST_WDATA_ACK: begin
            if (scl_fall) begin
              if (!ph_q) begin
                sda_oe_q <= 1'b1;
                ph_q     <= 1'b1;
                if (state_q == ST_DEV_ACK && rw_q) rd_q <= 1'b1;
              end else begin
                ph_q     <= 1'b0;
                sda_oe_q <= 1'b0;
                cnt_q    <= '0;
                if (state_q == ST_DEV_ACK && rw_q) begin
                  state_q  <= ST_RDATA;
                  sda_oe_q <= ~tx_q[7];
                  tx_q     <= {tx_q[6:0], 1'b0};
                end else if (state_q == ST_DEV_ACK) begin
                  state_q <= ST_REG;
                end else begin
                  state_q <= ST_WDATA;
                end
              end
            end
          end

          ST_RDATA: begin
            if (scl_rise) cnt_q <= cnt_q + 4'd1;
            if (scl_fall) begin
              if (cnt_q == 4'd8) begin
                sda_oe_q <= 1'b0;
                cnt_q    <= '0;
                ph_q     <= 1'b0;
                state_q  <= ST_MACK;
              end else begin
                sda_oe_q <= ~tx_q[7];
                tx_q     <= {tx_q[6:0], 1'b0};
              end
            end
          end

          ST_MACK: begin
            if (scl_rise && !ph_q) begin
              if (sda_s == ACK) begin
                addr_q <= addr_q + 8'd1;
                rd_q   <= 1'b1;
                ph_q   <= 1'b1;
              end else begin
                state_q <= ST_WAIT_STOP;
                busy_q  <= 1'b0;
              end
            end
            if (scl_fall && ph_q) begin
              ph_q     <= 1'b0;
              cnt_q    <= '0;
              state_q  <= ST_RDATA;
              sda_oe_q <= ~tx_q[7];
              tx_q     <= {tx_q[6:0], 1'b0};
            end
          end

          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.sda_oe    = sda_oe_q;
  assign bus.reg_wr_en = wr_q;
  assign bus.reg_rd_en = rd_q;
  assign bus.reg_addr  = addr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_cam_sccb_responder.sv
// Directed SCCB master bench with a strobe scoreboard for the register-bank port.
`timescale 1ns/1ps
module tb_cam_sccb_responder;
  import cam_sccb_pkg::*;

  localparam int Q = 12;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  logic clk, reset, scl_m, sda_m;
  int   total = 0;
  int   bad   = 0;
  wr_t        exp_wr_q[$];
  logic [7:0] exp_rd_q[$];

  cam_sccb_responder_if bus();

  assign bus.scl_in = scl_m;
  assign bus.sda_in = sda_m & ~bus.sda_oe;

  always @(posedge clk)
    if (bus.reg_rd_en) bus.reg_rdata <= bus.reg_addr ^ 8'h5A;

  cam_sccb_responder #(.DEV_ADDR(7'h21), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #500 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every strobe must match the oldest expected entry.
  always @(negedge clk) begin
    if (reset && bus.reg_wr_en) begin
      if (exp_wr_q.size() == 0) begin
        total++; bad++;
        $display("FAIL wr_unexpected: got addr %0h data %0h expected none", bus.reg_addr, bus.reg_wdata);
      end else begin
        wr_t e;
        e = exp_wr_q.pop_front();
        chk("wr_addr", bus.reg_addr, e.a);
        chk("wr_data", bus.reg_wdata, e.d);
        chk("wr_rd_excl", bus.reg_rd_en, 0);
      end
    end
    if (reset && bus.reg_rd_en) begin
      if (exp_rd_q.size() == 0) begin
        total++; bad++;
        $display("FAIL rd_unexpected: got addr %0h expected none", bus.reg_addr);
      end else begin
        logic [7:0] ea;
        ea = exp_rd_q.pop_front();
        chk("rd_addr", bus.reg_addr, ea);
      end
    end
  end

  initial begin
    #90_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic bus_bit(input logic b, output logic r);
    sda_m = b;    tick(Q);
    scl_m = 1'b1; tick(Q);
    r = bus.sda_in;
    tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], r);
    bus_bit(1'b1, ack);
  endtask

  task automatic rd_byte(input logic mack, output logic [7:0] d);
    logic r;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      bus_bit(1'b1, r);
      d = {d[6:0], r};
    end
    bus_bit(mack, r);
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_wr_q.push_back(e);
  endtask

  logic       ack, r;
  logic [7:0] d;
  logic [7:0] burst [5] = '{8'h42, 8'hFE, 8'h11, 8'h22, 8'h33};

  initial begin
    reset = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
    tick(5);
    chk("rst_sda_oe", bus.sda_oe, 0);
    chk("rst_wr_en", bus.reg_wr_en, 0);
    chk("rst_rd_en", bus.reg_rd_en, 0);
    chk("rst_addr", bus.reg_addr, 0);
    chk("rst_wdata", bus.reg_wdata, 0);
    chk("rst_busy", bus.busy, 0);
    reset = 1'b1;
    tick(10);

    // single write 42/12/80
    push_wr(8'h12, 8'h80);
    bus_start();
    wr_byte(SCCB_WR_ADDR, ack); chk("w1_ack_dev", ack, ACK);
    chk("w1_busy", bus.busy, 1);
    wr_byte(8'h12, ack); chk("w1_ack_reg", ack, ACK);
    wr_byte(8'h80, ack); chk("w1_ack_dat", ack, ACK);
    bus_stop();
    tick(Q);
    chk("w1_busy_stop", bus.busy, 0);
    chk("w1_ptr", bus.reg_addr, 8'h13);

    // burst write with pointer wrap
    push_wr(8'hFE, 8'h11);
    push_wr(8'hFF, 8'h22);
    push_wr(8'h00, 8'h33);
    bus_start();
    for (int i = 0; i < 5; i++) begin
      wr_byte(burst[i], ack);
      chk("burst_ack", ack, ACK);
    end
    bus_stop();
    tick(Q);
    chk("burst_ptr", bus.reg_addr, 8'h01);

    // two-phase read: set pointer 0A, then read two bytes
    bus_start();
    wr_byte(SCCB_WR_ADDR, ack); chk("rp_ack_dev", ack, ACK);
    wr_byte(8'h0A, ack);        chk("rp_ack_reg", ack, ACK);
    bus_stop();
    exp_rd_q.push_back(8'h0A);
    exp_rd_q.push_back(8'h0B);
    bus_start();
    wr_byte(SCCB_RD_ADDR, ack); chk("rd_ack_dev", ack, ACK);
    rd_byte(ACK, d);  chk("rd_byte0", d, 8'h50);
    rd_byte(NACK, d); chk("rd_byte1", d, 8'h51);
    tick(Q);
    chk("rd_release", bus.sda_oe, 0);
    chk("rd_busy_nack", bus.busy, 0);
    bus_stop();

    // foreign address
    bus_start();
    wr_byte(8'h44, ack); chk("na_ack_dev", ack, NACK);
    chk("na_busy", bus.busy, 0);
    wr_byte(8'h55, ack); chk("na_ack_dat", ack, NACK);
    chk("na_busy2", bus.busy, 0);
    bus_stop();
    tick(Q);
    chk("na_busy_stop", bus.busy, 0);

    // repeated START after pointer byte
    bus_start();
    wr_byte(SCCB_WR_ADDR, ack); chk("rs_ack_dev", ack, ACK);
    wr_byte(8'h12, ack);        chk("rs_ack_reg", ack, ACK);
    bus_start();
    chk("rs_ptr", bus.reg_addr, 8'h12);
    wr_byte(SCCB_WR_ADDR, ack); chk("rs_ack_dev2", ack, ACK);
    bus_stop();
    tick(Q);
    chk("rs_ptr_end", bus.reg_addr, 8'h12);

    // reset while driving bit 0 of 0x48 (a low bit, so SDA is pulled)
    exp_rd_q.push_back(8'h12);
    bus_start();
    wr_byte(SCCB_RD_ADDR, ack); chk("mr_ack_dev", ack, ACK);
    for (int i = 0; i < 7; i++) bus_bit(1'b1, r);
    chk("mr_drive_b0", bus.sda_oe, 1);
    reset = 1'b0;
    tick(1);
    chk("mr_sda_oe", bus.sda_oe, 0);
    chk("mr_busy", bus.busy, 0);
    chk("mr_addr", bus.reg_addr, 0);
    chk("mr_wdata", bus.reg_wdata, 0);
    chk("mr_wr_en", bus.reg_wr_en, 0);
    chk("mr_rd_en", bus.reg_rd_en, 0);
    tick(3);
    reset = 1'b1;
    tick(Q);
    wr_byte(SCCB_WR_ADDR, ack); chk("mr_nostart_ack", ack, NACK);
    bus_stop();

    push_wr(8'h05, 8'h77);
    bus_start();
    wr_byte(SCCB_WR_ADDR, ack); chk("post_ack_dev", ack, ACK);
    wr_byte(8'h05, ack);        chk("post_ack_reg", ack, ACK);
    wr_byte(8'h77, ack);        chk("post_ack_dat", ack, ACK);
    bus_stop();
    tick(2 * Q);

    chk("sb_wr_left", exp_wr_q.size(), 0);
    chk("sb_rd_left", exp_rd_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
